calc_engine_param: RTL

//  Parametrised successor of the keypad calculator FSM. Takes an ASCII key stream
//  "A op B Y" (A, B up to MAX_DIGITS decimal digits) over a valid/ready handshake.

---
 rtl/calc_engine_param.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_engine_param.sv
// Keypad calculator engine: ASCII "A op B Y" keys in, "=<result>\r\n" line out.
// Optional macro CALC_SUB_EN adds '-' as an operator with signed result display.
module calc_engine_param #(
    parameter int MAX_DIGITS = 3,
    parameter int OPW        = 10
) (
    input  logic       USER_CLK,
    input  logic       RESET,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic       key_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [3:0] calcstate
);
    // state   | meaning
    // A_IN    | collecting digits of operand A
    // OP_WAIT | A full, waiting for operator
    // B_IN    | collecting digits of operand B, 'Y' evaluates
    // EVAL    | one-cycle arithmetic / compare
    // CONV    | double-dabble binary to BCD, one bit per cycle
    // EMIT    | streaming the result line
    // ABORT   | streaming "ESC\r\n"
    localparam int RW = 2 * OPW;
    localparam int RD = 2 * MAX_DIGITS;
    localparam int NW = $clog2(MAX_DIGITS + 1);
    localparam int CW = $clog2(RW + 1);
    localparam int DW = $clog2(RD);

    typedef enum logic [3:0] {
        A_IN = 4'd0, OP_WAIT = 4'd1, B_IN = 4'd2, EVAL = 4'd3,
        CONV = 4'd4, EMIT = 4'd5, ABORT = 4'd6
    } state_t;
    typedef enum logic [2:0] {PH_EQ, PH_NEG, PH_DIG, PH_TXT, PH_CR, PH_LF} phase_t;

    localparam logic [2:0] OP_ADD = 3'd0, OP_MUL = 3'd1, OP_LT = 3'd2, OP_GT = 3'd3;
`ifdef CALC_SUB_EN
    localparam logic [2:0] OP_SUB = 3'd4;
`endif
    localparam logic [1:0] TXT_TRUE = 2'd0, TXT_FALSE = 2'd1, TXT_ESC = 2'd2;

    state_t          state_q, state_d;
    phase_t          ph_q;
    logic            started_q;
    logic [OPW-1:0]  a_q, b_q, acc_next;
    logic [NW-1:0]   cnt_q;
    logic [2:0]      op_q, op_code;
    logic [RW-1:0]   bin_q;
    logic [4*RD-1:0] bcd_q, bcd_sh, bcd_adj;
    logic [CW-1:0]   conv_q;
    logic            neg_q;
    logic [1:0]      txt_sel_q;
    logic [2:0]      txt_idx_q;
    logic [DW-1:0]   dig_q, lead;
    logic            in_state, key_acc, out_fire;
    logic            is_digit, is_op, is_yes, is_no, cnt_zero, op_is_cmp, txt_last;
    logic [7:0]      txt_char;

    assign in_state  = state_q inside {A_IN, OP_WAIT, B_IN};
    assign key_ready = started_q && in_state;
    assign key_acc   = key_valid && key_ready;
    assign out_valid = (state_q == EMIT) || (state_q == ABORT);
    assign out_fire  = out_valid && out_ready;
    assign busy      = !in_state;
    assign calcstate = state_q;

    assign is_digit  = (key_data >= 8'h30) && (key_data <= 8'h39);
    assign is_yes    = (key_data == 8'h59);
    assign is_no     = (key_data == 8'h4E);
    assign cnt_zero  = (cnt_q == '0);
    assign op_is_cmp = (op_q == OP_LT) || (op_q == OP_GT);
    assign acc_next  = OPW'(((state_q == B_IN) ? b_q : a_q) * OPW'(10) + OPW'(key_data[3:0]));

    always_comb begin
        is_op   = 1'b1;
        op_code = OP_ADD;
        case (key_data)
            8'h2B:   op_code = OP_ADD;
            8'h2A:   op_code = OP_MUL;
            8'h3C:   op_code = OP_LT;
            8'h3E:   op_code = OP_GT;
`ifdef CALC_SUB_EN
            8'h2D:   op_code = OP_SUB;
`endif
            default: is_op = 1'b0;
        endcase
    end

    // Register holds the shifted-then-adjusted value; the final shift skips the adjust.
    assign bcd_sh = {bcd_q[4*RD-2:0], bin_q[RW-1]};
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < RD; i++)
            if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < RD; i++)
            if (bcd_q[4*i +: 4] != 4'd0) lead = DW'(i);
    end

    always_comb begin
        txt_char = 8'h00;
        txt_last = 1'b0;
        case (txt_sel_q)
            TXT_TRUE: begin
                case (txt_idx_q)
                    3'd0: txt_char = "T";
                    3'd1: txt_char = "R";
                    3'd2: txt_char = "U";
                    default: txt_char = "E";
                endcase
                txt_last = (txt_idx_q == 3'd3);
            end
            TXT_FALSE: begin
                case (txt_idx_q)
                    3'd0: txt_char = "F";
                    3'd1: txt_char = "A";
                    3'd2: txt_char = "L";
                    3'd3: txt_char = "S";
                    default: txt_char = "E";
                endcase
                txt_last = (txt_idx_q == 3'd4);
            end
            default: begin
                case (txt_idx_q)
                    3'd0: txt_char = "E";
                    3'd1: txt_char = "S";
                    default: txt_char = "C";
                endcase
                txt_last = (txt_idx_q == 3'd2);
            end
        endcase
    end

    always_comb begin
        out_data = 8'h00;
        out_last = 1'b0;
        if (out_valid) begin
            case (ph_q)
                PH_EQ:  out_data = "=";
                PH_NEG: out_data = "-";
                PH_DIG: out_data = {4'h3, bcd_q[{dig_q, 2'b00} +: 4]};
                PH_TXT: out_data = txt_char;
                PH_CR:  out_data = 8'h0D;
                PH_LF: begin
                    out_data = 8'h0A;
                    out_last = 1'b1;
                end
                default: out_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (!RESET) state_q <= A_IN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_IN, OP_WAIT, B_IN: begin
                if (key_acc) begin
                    if (is_no)
                        state_d = ABORT;
                    else if (state_q == A_IN && is_digit && cnt_q == NW'(MAX_DIGITS - 1))
                        state_d = OP_WAIT;
                    else if (state_q != B_IN && is_op && !cnt_zero)
                        state_d = B_IN;
                    else if (state_q == B_IN && is_yes && !cnt_zero)
                        state_d = EVAL;
                end
            end
            EVAL:        state_d = op_is_cmp ? EMIT : CONV;
            CONV:        if (conv_q == CW'(1)) state_d = EMIT;
            EMIT, ABORT: if (out_fire && ph_q == PH_LF) state_d = A_IN;
            default:     state_d = A_IN;
        endcase
    end

    always_ff @(posedge USER_CLK) begin
        if (!RESET) begin
            started_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            bin_q     <= '0;
            bcd_q     <= '0;
            conv_q    <= '0;
            neg_q     <= 1'b0;
            ph_q      <= PH_EQ;
            txt_sel_q <= TXT_TRUE;
            txt_idx_q <= '0;
            dig_q     <= '0;
        end else begin
            started_q <= 1'b1;
            case (state_q)
                A_IN, OP_WAIT, B_IN: begin
                    if (key_acc) begin
                        if (is_no) begin
                            a_q       <= '0;
                            b_q       <= '0;
                            cnt_q     <= '0;
                            op_q      <= OP_ADD;
                            ph_q      <= PH_TXT;
                            txt_sel_q <= TXT_ESC;
                            txt_idx_q <= '0;
                        end else if (is_digit && state_q != OP_WAIT && cnt_q != NW'(MAX_DIGITS)) begin
                            if (state_q == B_IN) b_q <= acc_next;
                            else                 a_q <= acc_next;
                            cnt_q <= cnt_q + 1'b1;
                        end else if (is_op && state_q != B_IN && !cnt_zero) begin
                            op_q  <= op_code;
                            cnt_q <= '0;
                        end
                    end
                end
                EVAL: begin
                    bcd_q     <= '0;
                    conv_q    <= CW'(RW);
                    ph_q      <= PH_EQ;
                    txt_idx_q <= '0;
                    txt_sel_q <= TXT_FALSE;
                    neg_q     <= 1'b0;
                    case (op_q)
                        OP_MUL: bin_q <= RW'(a_q) * RW'(b_q);
                        OP_LT:  if (a_q < b_q) txt_sel_q <= TXT_TRUE;
                        OP_GT:  if (a_q > b_q) txt_sel_q <= TXT_TRUE;
`ifdef CALC_SUB_EN
                        OP_SUB: begin
                            neg_q <= (a_q < b_q);
                            bin_q <= (a_q < b_q) ? RW'(b_q - a_q) : RW'(a_q - b_q);
                        end
`endif
                        default: bin_q <= RW'(a_q) + RW'(b_q);
                    endcase
                end
                CONV: begin
                    bin_q  <= {bin_q[RW-2:0], 1'b0};
                    bcd_q  <= (conv_q == CW'(1)) ? bcd_sh : bcd_adj;
                    conv_q <= conv_q - 1'b1;
                end
                EMIT, ABORT: begin
                    if (out_fire) begin
                        case (ph_q)
                            PH_EQ: begin
                                if (neg_q)          ph_q <= PH_NEG;
                                else if (op_is_cmp) ph_q <= PH_TXT;
                                else begin
                                    ph_q  <= PH_DIG;
                                    dig_q <= lead;
                                end
                            end
                            PH_NEG: begin
                                ph_q  <= PH_DIG;
                                dig_q <= lead;
                            end
                            PH_DIG: if (dig_q == '0) ph_q <= PH_CR; else dig_q <= dig_q - 1'b1;
                            PH_TXT: if (txt_last) ph_q <= PH_CR; else txt_idx_q <= txt_idx_q + 1'b1;
                            PH_CR:  ph_q <= PH_LF;
                            default: begin
                                a_q   <= '0;
                                b_q   <= '0;
                                cnt_q <= '0;
                                op_q  <= OP_ADD;
                                neg_q <= 1'b0;
                                ph_q  <= PH_EQ;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
